// File: rtl/seq_det_ctrl_if.sv
// Word handshake between a producer and the sequence-detector controller.
//   in_valid : producer has a word on in_data
//   in_data  : word to scan, serialised MSB-first
//   in_ready : controller accepts the word this cycle
interface seq_det_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Session controller for a programmable serial Mealy pattern detector.
// Accepts words over a valid/ready handshake, shifts each one MSB-first into
// the comparator, counts matches over cfg_words words, then pulses done.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cfg_we/cfg_pattern/cfg_overlap  pattern config, honoured in IDLE only
//   cfg_words, start      session length and launch, honoured in IDLE only
//   bus (slave)           in_valid / in_data / in_ready word handshake
//   det_bit, det_hit      serial bit under test and its Mealy match pulse
//   match_count           saturating match count of current/last session
//   busy, done            not-idle flag and one-cycle end-of-session pulse
module seq_det_ctrl #(
    parameter int unsigned     PAT_W       = 5,
    parameter int unsigned     DATA_W      = 8,
    parameter int unsigned     CNT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(5'b11010)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [7:0]       cfg_words,
    input  logic             start,
    seq_det_ctrl_if.slave    bus,
    output logic             det_bit,
    output logic             det_hit,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned FILL_W = $clog2(PAT_W);
    localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PAT_W-1:0]   pattern_q;
    logic               overlap_q;
    logic [HIST_W-1:0]  hist_q;
    logic [FILL_W-1:0]  fill_q;
    logic [7:0]         words_left_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [DATA_W-1:0]  sreg_q;
    logic               in_ready_c;
    logic [PAT_W-1:0]   candidate_c;

    assign bus.in_ready = in_ready_c;
    assign candidate_c  = {hist_q, sreg_q[DATA_W-1]};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs, including the Mealy hit
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        det_bit    = 1'b0;
        det_hit    = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (cfg_words == 8'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                det_bit = sreg_q[DATA_W-1];
                det_hit = (fill_q == FILL_FULL) && (candidate_c == pattern_q);
                if (bit_idx_q == IDX_LAST) begin
                    state_d = (words_left_q == 8'd1) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Config, serialiser, match history and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q    <= RST_PATTERN;
            overlap_q    <= 1'b1;
            hist_q       <= '0;
            fill_q       <= '0;
            words_left_q <= '0;
            bit_idx_q    <= '0;
            sreg_q       <= '0;
            match_count  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Config written alongside start applies to that session
                    if (cfg_we) begin
                        pattern_q <= cfg_pattern;
                        overlap_q <= cfg_overlap;
                    end
                    if (start) begin
                        match_count  <= '0;
                        hist_q       <= '0;
                        fill_q       <= '0;
                        words_left_q <= cfg_words;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        sreg_q    <= bus.in_data;
                        bit_idx_q <= '0;
                    end
                end
                S_SHIFT: begin
                    sreg_q    <= sreg_q << 1;
                    bit_idx_q <= bit_idx_q + 1'b1;
                    // Oldest bit falls off the top; history spans word boundaries
                    hist_q    <= HIST_W'({hist_q, sreg_q[DATA_W-1]});
                    if (det_hit && !overlap_q) begin
                        fill_q <= '0;
                    end else if (fill_q != FILL_FULL) begin
                        fill_q <= fill_q + 1'b1;
                    end
                    if (det_hit && (match_count != '1)) begin
                        match_count <= match_count + 1'b1;
                    end
                    if (bit_idx_q == IDX_LAST) begin
                        words_left_q <= words_left_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: table of directed sessions, random
// sessions against a bit-stream reference model, and a mid-session reset.
module tb_seq_det_ctrl;

    localparam int unsigned PAT_W  = 5;
    localparam int unsigned DATA_W = 8;

    typedef struct packed {
        logic [4:0]      pattern;
        logic            overlap;
        logic [7:0]      nwords;
        logic [3:0][7:0] words;
        logic [7:0]      gap;
        logic            inject;
        int              exp_count;   // -1: take count from the model
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [4:0] cfg_pattern;
    logic       cfg_overlap;
    logic [7:0] cfg_words;
    logic       start;
    logic       det_bit, det_hit, busy, done;
    logic [7:0] match_count;
    logic       det_bit_s, det_hit_s, busy_s, done_s;
    logic [1:0] match_count_s;

    int n_vec = 0;
    int n_bad = 0;

    seq_det_ctrl_if #(.DATA_W(DATA_W)) bus ();
    seq_det_ctrl_if #(.DATA_W(DATA_W)) bus_s ();

    assign bus_s.in_valid = bus.in_valid;
    assign bus_s.in_data  = bus.in_data;

    always #5 clk = ~clk;

    seq_det_ctrl #(.PAT_W(PAT_W), .DATA_W(DATA_W), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .cfg_words(cfg_words), .start(start),
        .bus(bus), .det_bit(det_bit), .det_hit(det_hit),
        .match_count(match_count), .busy(busy), .done(done)
    );

    seq_det_ctrl #(.PAT_W(PAT_W), .DATA_W(DATA_W), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .cfg_words(cfg_words), .start(start),
        .bus(bus_s), .det_bit(det_bit_s), .det_hit(det_hit_s),
        .match_count(match_count_s), .busy(busy_s), .done(done_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [4:0] p, input logic o, input int n,
                                input logic [7:0] w0, input logic [7:0] w1,
                                input int g, input logic inj, input int ec);
        vec_t v;
        v.pattern   = p;
        v.overlap   = o;
        v.nwords    = 8'(n);
        v.words     = {8'h00, 8'h00, w1, w0};
        v.gap       = 8'(g);
        v.inject    = inj;
        v.exp_count = ec;
        return v;
    endfunction

    // Reference: flatten the session into one bit stream, then slide a window.
    // A match is legal once PAT_W bits have arrived since the session start
    // (or since the previous match when overlap is off).
    function automatic void model(input vec_t v, output logic [31:0] bits,
                                  output logic [31:0] hits, output int cnt);
        int n;
        int ok;
        logic [4:0] win;
        n    = int'(v.nwords) * DATA_W;
        ok   = 0;
        cnt  = 0;
        bits = '0;
        hits = '0;
        for (int w = 0; w < int'(v.nwords); w++)
            for (int b = 0; b < DATA_W; b++)
                bits[w*DATA_W + b] = v.words[w][DATA_W-1-b];
        for (int i = 0; i < n; i++) begin
            if (i >= ok + PAT_W - 1) begin
                for (int k = 0; k < PAT_W; k++)
                    win[PAT_W-1-k] = bits[i-(PAT_W-1)+k];
                if (win == v.pattern) begin
                    hits[i] = 1'b1;
                    cnt++;
                    if (!v.overlap) ok = i + 1;
                end
            end
        end
    endfunction

    task automatic run_session(input vec_t v, input logic do_cfg);
        logic [31:0] bits, hits;
        int          cnt;
        int          exp_cnt;
        int          exp_small;
        int          pos;
        model(v, bits, hits, cnt);
        exp_cnt   = (v.exp_count >= 0) ? v.exp_count : cnt;
        exp_small = (exp_cnt > 3) ? 3 : exp_cnt;

        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(bus.in_ready), 32'd0);
        cfg_we      = do_cfg;
        cfg_pattern = v.pattern;
        cfg_overlap = v.overlap;
        cfg_words   = v.nwords;
        start       = 1'b1;
        step();
        cfg_we = 1'b0;
        start  = 1'b0;

        pos = 0;
        for (int w = 0; w < int'(v.nwords); w++) begin
            if (w > 0) begin
                bus.in_valid = 1'b0;
                for (int g = 0; g < int'(v.gap); g++) begin
                    check("stall_ready", 32'(bus.in_ready), 32'd1);
                    step();
                end
            end
            check("load_ready", 32'(bus.in_ready), 32'd1);
            check("load_hit", 32'(det_hit), 32'd0);
            bus.in_valid = 1'b1;
            bus.in_data  = v.words[w];
            step();
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            for (int b = 0; b < DATA_W; b++) begin
                check("shift_bit", 32'(det_bit), 32'(bits[pos]));
                check("shift_hit", 32'(det_hit), 32'(hits[pos]));
                check("shift_ready", 32'(bus.in_ready), 32'd0);
                check("shift_done", 32'(done), 32'd0);
                if (v.inject && w == 0 && b == 2) begin
                    cfg_we      = 1'b1;
                    cfg_pattern = 5'b11111;
                    cfg_overlap = 1'b0;
                    cfg_words   = 8'd0;
                    start       = 1'b1;
                end
                step();
                cfg_we = 1'b0;
                start  = 1'b0;
                pos++;
            end
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("end_done", 32'(done), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("count", 32'(match_count), 32'(exp_cnt));
        check("count_sat", 32'(match_count_s), 32'(exp_small));
    endtask

    vec_t tbl[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        tbl[0] = mk(5'b11010, 1'b1, 1, 8'b11010110, 8'h00, 0, 1'b0, 1);
        tbl[1] = mk(5'b10101, 1'b1, 1, 8'b10101010, 8'h00, 0, 1'b0, 2);
        tbl[2] = mk(5'b10101, 1'b0, 1, 8'b10101010, 8'h00, 0, 1'b0, 1);
        tbl[3] = mk(5'b11010, 1'b1, 2, 8'b00000110, 8'b10000000, 3, 1'b0, 1);
        tbl[4] = mk(5'b00000, 1'b1, 1, 8'h00, 8'h00, 0, 1'b0, 4);
        tbl[5] = mk(5'b11010, 1'b1, 0, 8'h00, 8'h00, 0, 1'b0, 0);
        tbl[6] = mk(5'b11010, 1'b1, 1, 8'b11010110, 8'h00, 0, 1'b1, 1);
        tbl[7] = mk(5'b00000, 1'b0, 2, 8'h00, 8'h00, 1, 1'b0, 3);

        reset        = 1'b1;
        cfg_we       = 1'b0;
        cfg_pattern  = 5'b0;
        cfg_overlap  = 1'b0;
        cfg_words    = 8'd0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1;
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hit", 32'(det_hit), 32'd0);
        check("rst_bit", 32'(det_bit), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_session(tbl[i], 1'b1);

        for (int r = 0; r < 40; r++) begin
            v.pattern = 5'($urandom);
            v.overlap = 1'($urandom);
            v.nwords  = 8'($urandom_range(0, 4));
            for (int w = 0; w < 4; w++)
                v.words[w] = ($urandom_range(0, 1) == 1) ? 8'($urandom)
                                                         : {v.pattern[2:0], v.pattern};
            v.gap       = 8'($urandom_range(0, 2));
            v.inject    = 1'($urandom);
            v.exp_count = -1;
            run_session(v, 1'b1);
        end

        // Reset during the third SHIFT cycle of the second word
        cfg_we      = 1'b1;
        cfg_pattern = 5'b11010;
        cfg_overlap = 1'b1;
        cfg_words   = 8'd2;
        start       = 1'b1;
        step();
        cfg_we = 1'b0;
        start  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'b11010110;
        step();
        bus.in_valid = 1'b0;
        for (int b = 0; b < DATA_W; b++) step();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        check("pre_rst_count", 32'(match_count), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_ready", 32'(bus.in_ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hit", 32'(det_hit), 32'd0);
        check("arst_count", 32'(match_count), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("arst_hold_done", 32'(done), 32'd0);
        end
        reset = 1'b0;
        step();
        check("post_rst_done", 32'(done), 32'd0);
        // Reset pattern 11010 with overlap must be back without a config write
        run_session(mk(5'b11010, 1'b1, 1, 8'b11010110, 8'h00, 0, 1'b0, 1), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Session controller for a serial pattern detector of the 11010 Mealy kind, with a programmable pattern.
- Accepts parallel words over a valid/ready handshake and serialises each one MSB-first, one bit per clock, into an embedded Mealy comparator.
- Counts matches over a session of a configured number of words, then signals completion.
- Sits between a word-oriented producer and the serial detection datapath, and owns configuration, sequencing and result reporting.

Parameters:
- PAT_W, 5, pattern length in bits (PAT_W ≥ 2).
- DATA_W, 8, input word width in bits.
- CNT_W, 8, match counter width.
- RST_PATTERN, 5'b11010, pattern value loaded on reset (PAT_W bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_we  input  1  write pattern/overlap config; honoured only in IDLE.
- cfg_pattern  input  PAT_W  pattern to detect; MSB is the oldest bit.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cfg_words  input  8  words per session; sampled on start.
- start  input  1  begin session; honoured only in IDLE.
- in_valid  input  1  producer has a word.
- in_data  input  DATA_W  word to scan.
- in_ready  output  1  controller accepts a word this cycle.
- det_bit  output  1  bit currently presented to the detector.
- det_hit  output  1  Mealy match pulse for the current det_bit.
- match_count  output  CNT_W  matches in the current or last session; saturating.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle end-of-session pulse.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - pattern = RST_PATTERN, overlap = 1.
  - History, fill counter, words_left, bit index and shift register clear.
  - match_count = 0.
  - Outputs in_ready = 0, det_bit = 0, det_hit = 0, busy = 0, done = 0.
  - Reset mid-session aborts the session with no done pulse.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cfg_we latches cfg_pattern and cfg_overlap.
  - start clears match_count, history and fill, and latches words_left = cfg_words.
  - Next state is DONE if cfg_words == 0, otherwise LOAD.
  - If cfg_we and start arrive in the same cycle, the new config applies to the session.
- Outside IDLE: cfg_we and start are ignored.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready, the word is captured into the shift register, bit index = 0, next state SHIFT.
  - Without in_valid, stay in LOAD indefinitely.
- SHIFT:
  - det_bit = sreg[DATA_W-1]; sreg shifts left each cycle; exactly DATA_W cycles per word.
  - After the last bit, words_left decrements; next state is DONE if it reaches 0, else LOAD.
  - Each word costs DATA_W+1 cycles minimum (one LOAD bubble).
- DONE: done = 1 for exactly one cycle, then IDLE. match_count holds until the next start.
- Detector:
  - hist is PAT_W-1 bits; fill saturates at PAT_W-1.
  - candidate = {hist, det_bit}.
  - det_hit = (state == SHIFT) && (fill == PAT_W-1) && (candidate == pattern). It is combinational (Mealy), in the same cycle as det_bit.
  - Every SHIFT cycle: hist <= {hist[PAT_W-3:0], det_bit}, fill increments.
  - On a hit with overlap = 0: fill <= 0 instead, so the next match needs PAT_W fresh bits. hist is still updated.
  - On a hit: match_count increments, saturating at 2^CNT_W-1.
- History and fill persist across word boundaries within a session, so matches may span words. They clear only on start and on reset.
- det_bit = 0 and det_hit = 0 outside SHIFT.

Test Plan:
- Basic match: reset, start with cfg_words = 1, send 8'b11010110 → det_hit high only in SHIFT cycle 5 (bit index 4); done one cycle after the last SHIFT; match_count = 1; in_ready high only in LOAD.
- Overlap vs non-overlap: cfg_pattern = 5'b10101, words = 1, data 8'b10101010.
  - cfg_overlap = 1 → hits at bit indices 4 and 6, count = 2.
  - Repeat with cfg_overlap = 0 → single hit at index 4, count = 1.
- Cross-word match: pattern 11010, words = 2, data 8'b00000110 then 8'b10000000 → one hit at word 2, bit index 1; count = 1. Hold in_valid low 3 cycles before word 2 → LOAD stalls and the result is unchanged.
- Fill guard and saturation:
  - pattern 5'b00000, words = 1, data 8'h00 → no hit at indices 0–3, hits at 4–7, count = 4.
  - With CNT_W = 2 → count saturates at 3.
- Zero-length and ignored controls:
  - cfg_words = 0 with start → done on the next cycle, count = 0, in_ready never high.
  - During SHIFT, pulse start and cfg_we with pattern 5'b11111 → both ignored and the session result is unchanged.
- Reset mid-session: assert reset during SHIFT cycle 3 → in_ready/busy/det_hit/match_count go to 0 immediately with no clock edge, no done pulse. The next session detects 11010 again.
